// File: rtl/alu_op_sequencer_if.sv
// Request/result handshake bundle between execute control and the ALU sequencer.
// master drives requests and consumes results; slave is the sequencer.
interface alu_op_sequencer_if #(
   parameter int W = 64
);
   logic                in_valid;
   logic                in_ready;
   logic [3:0]          in_ifun;
   logic signed [W-1:0] in_a;
   logic signed [W-1:0] in_b;
   logic                in_set_cc;
   logic                out_valid;
   logic                out_ready;
   logic signed [W-1:0] out_result;
   logic                out_err;

   modport master (
      output in_valid, in_ifun, in_a, in_b, in_set_cc, out_ready,
      input  in_ready, out_valid, out_result, out_err
   );

   modport slave (
      input  in_valid, in_ifun, in_a, in_b, in_set_cc, out_ready,
      output in_ready, out_valid, out_result, out_err
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Y86-64 OPq sequencer: accept one request, execute a cycle later, hold the
// result until taken, and maintain the ZF/SF/OF condition-code register.
module alu_op_sequencer #(
   parameter int W     = 64,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   alu_op_sequencer_if.slave  bus,
   output logic               cc_zf,
   output logic               cc_sf,
   output logic               cc_of,
   output logic [CNT_W-1:0]   op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t              state;
   state_t              state_nxt;
   logic                accept;
   logic                handoff;

   logic [3:0]          ifun_p0;
   logic                set_cc_p0;
   logic signed [W-1:0] a_p0;
   logic signed [W-1:0] b_p0;

   logic signed [W-1:0] res_p1;
   logic                err_p1;
   logic                vld_p1;

   logic signed [W-1:0] alu_r;
   logic                alu_legal;
   logic                alu_ovf;

   // Result is B op A, matching "opq rA, rB" writing rB.
   function automatic logic signed [W-1:0] alu_result(
      input logic [3:0]          f,
      input logic signed [W-1:0] a,
      input logic signed [W-1:0] b
   );
      case (f)
         4'd0:    alu_result = b + a;
         4'd1:    alu_result = b - a;
         4'd2:    alu_result = b & a;
         4'd3:    alu_result = b ^ a;
         default: alu_result = '0;
      endcase
   endfunction

   function automatic logic alu_overflow(
      input logic [3:0]          f,
      input logic signed [W-1:0] a,
      input logic signed [W-1:0] b,
      input logic signed [W-1:0] r
   );
      case (f)
         4'd0:    alu_overflow = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         4'd1:    alu_overflow = (a[W-1] != b[W-1]) && (r[W-1] != b[W-1]);
         default: alu_overflow = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      accept       = 1'b0;
      handoff      = 1'b0;
      bus.in_ready = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = !rst;
            if (bus.in_valid) begin
               accept    = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC: state_nxt = DONE;
         DONE: begin
            if (bus.out_ready) begin
               handoff   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---- stage p0: operand capture on acceptance ----
   always_ff @(posedge clk) begin
      if (accept) begin
         ifun_p0   <= bus.in_ifun;
         set_cc_p0 <= bus.in_set_cc;
         a_p0      <= bus.in_a;
         b_p0      <= bus.in_b;
      end
   end

   always_comb begin
      alu_legal = (ifun_p0[3:2] == 2'b00);
      alu_r     = alu_result(ifun_p0, a_p0, b_p0);
      alu_ovf   = alu_overflow(ifun_p0, a_p0, b_p0, alu_r);
   end

   // ---- stage p1: execute, CC update, result hold ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1   <= 1'b0;
         res_p1   <= '0;
         err_p1   <= 1'b0;
         cc_zf    <= 1'b1;
         cc_sf    <= 1'b0;
         cc_of    <= 1'b0;
         op_count <= '0;
      end else if (state == EXEC) begin
         vld_p1   <= 1'b1;
         res_p1   <= alu_r;
         err_p1   <= !alu_legal;
         op_count <= op_count + CNT_W'(1);
         if (set_cc_p0 && alu_legal) begin
            cc_zf <= (alu_r == '0);
            cc_sf <= alu_r[W-1];
            cc_of <= alu_ovf;
         end
      end else if (handoff) begin
         vld_p1 <= 1'b0;
      end
   end

   assign bus.out_valid  = vld_p1;
   assign bus.out_result = res_p1;
   assign bus.out_err    = err_p1;

endmodule
